// File: rtl/adc_stream_arbiter_if.sv
// AXI-Stream bundle carrying N parallel lanes of W-bit data; N=1 is a plain stream.
// The master drives valid/data/last and the slave returns ready.
interface adc_stream_arbiter_if #(
   parameter int N = 1,
   parameter int W = 32
);
   logic [N-1:0]   tvalid;
   logic [N*W-1:0] tdata;
   logic [N-1:0]   tlast;
   logic [N-1:0]   tready;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC adc sample streams onto one AXI-Stream,
// with per-source enables, a runaway-packet length guard and a forwarded-packet counter.
module adc_stream_arbiter #(
   parameter int NUM_SRC       = 4,
   parameter int TDATA_WIDTH   = 32,
   parameter int MAX_PKT_WORDS = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SRC-1:0]         src_enable,
   adc_stream_arbiter_if.slave        s_axis,
   adc_stream_arbiter_if.master       m_axis,
   output logic                       grant_valid,
   output logic [$clog2(NUM_SRC)-1:0] grant_idx,
   output logic [NUM_SRC-1:0]         pkt_err,
   output logic [31:0]                pkt_count
);
   localparam int GW = $clog2(NUM_SRC);
   localparam int CW = $clog2(MAX_PKT_WORDS);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]         state;
   logic [GW-1:0]      rr_ptr;
   logic [CW-1:0]      word_cnt;
   logic [NUM_SRC-1:0] req;
   logic               any_req;
   logic [GW-1:0]      arb_idx;
   logic [GW-1:0]      next_ptr;
   logic               cap_last;
   logic               beat;

   assign req      = s_axis.tvalid & src_enable;
   assign cap_last = (word_cnt == CW'(MAX_PKT_WORDS - 1));
   assign next_ptr = (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + GW'(1);
   assign beat     = m_axis.tvalid & m_axis.tready;

   // First eligible requester scanning circularly upward from rr_ptr.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      any_req = 1'b0;
      arb_idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_SRC;
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            arb_idx = GW'(idx);
         end
      end
   end

   // Zero-latency pass-through of the granted lane while a packet is in flight.
   always_comb begin
      m_axis.tvalid = 1'b0;
      m_axis.tdata  = '0;
      m_axis.tlast  = 1'b0;
      s_axis.tready = '0;
      if (state == XFER) begin
         m_axis.tvalid            = s_axis.tvalid[grant_idx];
         m_axis.tdata             = s_axis.tdata[int'(grant_idx)*TDATA_WIDTH +: TDATA_WIDTH];
         m_axis.tlast             = s_axis.tlast[grant_idx] | cap_last;
         s_axis.tready[grant_idx] = m_axis.tready;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         word_cnt    <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         pkt_err     <= '0;
         pkt_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_idx   <= arb_idx;
                  grant_valid <= 1'b1;
                  word_cnt    <= '0;
                  state       <= XFER;
               end
            end
            XFER: begin
               if (beat) begin
                  word_cnt <= word_cnt + CW'(1);
                  if (m_axis.tlast) begin
                     state       <= IDLE;
                     grant_valid <= 1'b0;
                     rr_ptr      <= next_ptr;
                     pkt_count   <= pkt_count + 32'd1;
                     // Length guard cut the packet; the tail is re-arbitrated as a new packet.
                     if (!s_axis.tlast[grant_idx]) pkt_err[grant_idx] <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/adc_stream_arbiter.md
Name: adc_stream_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges the AXI-Stream sample outputs of up to NUM_SRC adc instances onto a single AXI-Stream toward the host DMA/FIFO.
- Each adc emits multi-word packets terminated by tlast. The arbiter never interleaves words from different packets.
- It also provides per-source enable masking, a runaway-packet guard and a forwarded-packet counter.

Parameters:
- NUM_SRC, 4, number of upstream adc streams (2..16).
- TDATA_WIDTH, 32, stream data width.
- MAX_PKT_WORDS, 16, maximum beats per packet before forced termination (>=2).
- GW, $clog2(NUM_SRC), grant index width (derived, localparam).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- src_enable  in  NUM_SRC  per-source arbitration enable (config register).
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  per-source data; source i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tdata  out  TDATA_WIDTH  merged data.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tready  in  1  downstream ready.
- grant_valid  out  1  high while a packet is being forwarded.
- grant_idx  out  GW  index of the granted source.
- pkt_err  out  NUM_SRC  sticky; bit i is set when source i overran MAX_PKT_WORDS.
- pkt_count  out  32  packets forwarded since reset; wraps at 2^32.

Behaviour:
- Reset (synchronous, active-high), taking effect the cycle after reset is sampled high:
  - state=IDLE, rr_ptr=0, word_cnt=0.
  - grant_valid=0, grant_idx=0, pkt_err=0, pkt_count=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
- Eligible request: req[i] = s_axis_tvalid[i] & src_enable[i].
- IDLE state:
  - All s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0.
  - If any req is high, register g = first i with req[i] high, searching circularly from rr_ptr. Then set grant_valid=1, grant_idx=g, word_cnt=0, state=XFER.
  - Otherwise remain in IDLE.
  - Arbitration latency: exactly 1 cycle in IDLE before the first beat can transfer, including between back-to-back packets.
- XFER state (combinational pass-through, zero added latency):
  - m_axis_tvalid = s_axis_tvalid[g]; m_axis_tdata = s_axis_tdata[g].
  - m_axis_tlast = s_axis_tlast[g] | (word_cnt == MAX_PKT_WORDS-1).
  - s_axis_tready[g] = m_axis_tready; all other readies are 0.
  - A beat is m_axis_tvalid & m_axis_tready; each beat increments word_cnt.
  - On a beat with m_axis_tlast=1:
    - state=IDLE, grant_valid=0, rr_ptr=(g+1) mod NUM_SRC, pkt_count += 1.
    - If s_axis_tlast[g]=0 (forced termination), set pkt_err[g]=1. The source's remaining words are arbitrated later as a new packet.
  - src_enable[g] dropping during XFER has no effect; the packet completes.
  - Sources with tvalid high but not granted are held (tready=0); no data is dropped.
- AXI rules:
  - While m_axis_tvalid & !m_axis_tready, m_axis_tdata/tlast are stable, as long as the source obeys AXI.
  - The arbiter never deasserts m_axis_tvalid on its own during XFER.
- Simultaneous events:
  - A new request in the same cycle as a tlast beat is seen in the following IDLE cycle.
  - reset has priority over every other event, including mid-packet; a partially forwarded packet is abandoned without counting.
- grant_idx holds its last value while grant_valid=0.

Test Plan:
1. Only src1 enabled; it sends a 3-word packet {0xA,0xB,0x0001_0001}, tready=1 -> grant_idx=1 one cycle after tvalid; 3 consecutive m beats, tlast on the 3rd; pkt_count=1; pkt_err=0.
2. All 4 sources continuously offer 2-word packets -> grant order 0,1,2,3,0,1; each packet is contiguous; 1 idle cycle between packets; pkt_count=6 after 6 packets.
3. Scenario 2 with m_axis_tready toggled pseudo-randomly -> scoreboard shows every word delivered once, in order per source; tdata held stable during stalls.
4. MAX_PKT_WORDS=16; src2 sends a 20-word packet -> first 16 words forwarded with forced tlast on word 16; pkt_err=4'b0100; remaining 4 words forwarded as a separate packet on src2's next grant; pkt_count=2.
5. src_enable=4'b1101 with all sources valid -> src1 never granted. Clearing src_enable[0] mid-packet from src0 -> that packet still completes.
6. reset asserted on the 2nd beat of a 3-word packet -> next cycle all outputs 0 and pkt_count=0; after release, the first grant goes to the lowest requesting index (rr_ptr=0).
